demux1x2_16bit_buf: RTL

DEMUX1X2_16BIT_BUF -- requirements
Module: demux1x2_16bit_buf

---
 rtl/demux1x2_16bit_buf_pkg.sv | 18 +
 rtl/demux_slot.sv | 63 ++++++
 rtl/demux1x2_16bit_buf.sv | 75 +++++++
 3 files changed

// File: rtl/demux1x2_16bit_buf_pkg.sv
// Shared definitions for the 1-to-2 buffered demultiplexer.
//   WIDTH_DEF / CNT_W_DEF : default data and delivery-counter widths
//   SEL_OUT0 / SEL_OUT1   : in_sel encodings for the two destinations
//   slot_state_e          : occupancy state of a single-entry output slot
package demux1x2_16bit_buf_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// Single-entry output slot with delivery counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : write data_i into the slot this edge
//   data_i     : word to store
//   ready_i    : downstream accepts the held word
//   data_o     : held word (kept after delivery)
//   valid_o    : slot is FULL
//   cnt_o      : number of delivered words, wrapping
module demux_slot
  import demux1x2_16bit_buf_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] cnt_o
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deliver;

  assign deliver = (state_q == SLOT_FULL) && ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // A load on the delivery edge wins, keeping the slot FULL with the new word.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (deliver) begin
      state_d = SLOT_EMPTY;
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (load_i) begin
      state_d = SLOT_FULL;
      data_d  = data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == SLOT_FULL);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux1x2_16bit_buf.sv
// 1-to-2 demultiplexer with a single-entry buffer per destination.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_data/in_sel/in_valid : source word, destination select, offer
//   in_ready                : selected destination can take a word
//   outN_data/valid/ready   : destination N stream (N = 0, 1)
//   cnt0, cnt1              : words delivered per destination, wrapping
module demux1x2_16bit_buf
  import demux1x2_16bit_buf_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic accept;
  logic load0, load1;

  // Only the selected slot can stall the source; a slot that is draining
  // this cycle can be refilled on the same edge.
  always_comb begin
    in_ready = 1'b1;
    if (in_sel == SEL_OUT1) begin
      in_ready = ~out1_valid | out1_ready;
    end else begin
      in_ready = ~out0_valid | out0_ready;
    end
  end

  assign accept = in_valid & in_ready;
  assign load0  = accept & (in_sel == SEL_OUT0);
  assign load1  = accept & (in_sel == SEL_OUT1);

  demux_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load0),
    .data_i  (in_data),
    .ready_i (out0_ready),
    .data_o  (out0_data),
    .valid_o (out0_valid),
    .cnt_o   (cnt0)
  );

  demux_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load1),
    .data_i  (in_data),
    .ready_i (out1_ready),
    .data_o  (out1_data),
    .valid_o (out1_valid),
    .cnt_o   (cnt1)
  );

endmodule
